door_lock_controller: RTL and testbench



---
 rtl/door_lock_pkg.sv | 19 +
 rtl/lock_timer.sv | 28 ++
 rtl/door_lock_controller.sv | 134 +++++++++++++
 tb/tb_door_lock_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/door_lock_pkg.sv
// rtl/door_lock_pkg.sv - shared types and constants for the door-lock controller
package door_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    CHECK    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } lock_state_e;

  localparam logic [3:0] DISP_LOCKED_HI = 4'hE;
  localparam logic [3:0] DISP_OPEN_HI   = 4'h0;
  localparam logic [7:0] DISP_LOCKOUT   = 8'hFF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter shared by the unlock and lockout windows
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt;

  // Decrement only while nonzero so the count can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/door_lock_controller.sv
// rtl/door_lock_controller.sv - press detect, code compare, timed unlock and attempt lockout
module door_lock_controller
  import door_lock_pkg::*;
#(
  parameter logic [3:0]  PASSWORD       = 4'hA,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       check_btn,
  input  logic [3:0] password_input,
  output logic       unlock,
  output logic       lockout,
  output logic [3:0] attempts_left,
  output logic [7:0] display_out,
  output logic       busy
);

  localparam int unsigned MAX_CYC = max_u(UNLOCK_CYCLES, LOCKOUT_CYCLES);
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [3:0] ATT_INIT = 4'(MAX_ATTEMPTS);
  localparam logic [4:0] ATT_MAX5 = 5'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0] UNLOCK_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

  lock_state_e      state, state_n;
  logic             btn_prev;
  logic             press;
  logic [3:0]       pw_q, pw_n;
  logic [3:0]       fail_q, fail_n;
  logic [4:0]       fail_inc;
  logic [3:0]       att_n;
  logic [7:0]       disp_n;
  logic             tmr_load, tmr_dec, tmr_done;
  logic [CNT_W-1:0] tmr_value;

  assign press    = check_btn & ~btn_prev;
  assign fail_inc = {1'b0, fail_q} + 5'd1;

  lock_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .done       (tmr_done)
  );

  always_comb begin
    state_n   = state;
    pw_n      = pw_q;
    fail_n    = fail_q;
    att_n     = attempts_left;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_dec   = 1'b0;
    case (state)
      LOCKED: begin
        if (press) begin
          pw_n    = password_input;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (pw_q == PASSWORD) begin
          state_n   = UNLOCKED;
          fail_n    = 4'd0;
          att_n     = ATT_INIT;
          tmr_load  = 1'b1;
          tmr_value = UNLOCK_LOAD;
        end else if (fail_inc < ATT_MAX5) begin
          state_n = LOCKED;
          fail_n  = fail_inc[3:0];
          att_n   = attempts_left - 4'd1;
        end else begin
          state_n   = LOCKOUT;
          fail_n    = fail_inc[3:0];
          att_n     = 4'd0;
          tmr_load  = 1'b1;
          tmr_value = LOCKOUT_LOAD;
        end
      end
      UNLOCKED: begin
        // A press here only relocks; the entry is not captured.
        if (press || tmr_done) state_n = LOCKED;
        else                   tmr_dec = 1'b1;
      end
      LOCKOUT: begin
        if (tmr_done) begin
          state_n = LOCKED;
          fail_n  = 4'd0;
          att_n   = ATT_INIT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_n = LOCKED;
    endcase

    // Outputs are registered from the next-state values to keep them glitch-free.
    case (state_n)
      UNLOCKED: disp_n = {DISP_OPEN_HI, pw_n};
      LOCKOUT:  disp_n = DISP_LOCKOUT;
      default:  disp_n = {DISP_LOCKED_HI, pw_n};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOCKED;
      btn_prev      <= 1'b0;
      pw_q          <= 4'd0;
      fail_q        <= 4'd0;
      attempts_left <= ATT_INIT;
      display_out   <= {DISP_LOCKED_HI, 4'd0};
      unlock        <= 1'b0;
      lockout       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      btn_prev      <= check_btn;
      pw_q          <= pw_n;
      fail_q        <= fail_n;
      attempts_left <= att_n;
      display_out   <= disp_n;
      unlock        <= (state_n == UNLOCKED);
      lockout       <= (state_n == LOCKOUT);
      busy          <= (state_n != LOCKED);
    end
  end

endmodule

// File: tb/tb_door_lock_controller.sv
// tb/tb_door_lock_controller.sv - randomized and directed bench against a behavioural lock model
module tb_door_lock_controller;

  localparam logic [3:0] PW   = 4'hA;
  localparam int         MAXA = 3;
  localparam int         UC   = 8;
  localparam int         LC   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       check_btn = 1'b0;
  logic [3:0] password_input = 4'd0;
  logic       unlock, lockout, busy;
  logic [3:0] attempts_left;
  logic [7:0] display_out;
  logic [14:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: pending compare flag, remaining open/alarm cycles, consecutive fails.
  logic       m_prev;
  logic       m_pending;
  logic [3:0] m_code;
  int         m_open, m_alarm, m_fails;

  always #5 clk = ~clk;

  door_lock_controller #(
    .PASSWORD(PW), .MAX_ATTEMPTS(MAXA), .UNLOCK_CYCLES(UC), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .check_btn(check_btn), .password_input(password_input),
    .unlock(unlock), .lockout(lockout), .attempts_left(attempts_left),
    .display_out(display_out), .busy(busy)
  );

  assign obs = {unlock, lockout, busy, attempts_left, display_out};

  task automatic model_reset();
    m_prev = 1'b0; m_pending = 1'b0; m_code = 4'd0;
    m_open = 0; m_alarm = 0; m_fails = 0;
  endtask

  task automatic model_step(input logic b, input logic [3:0] p);
    logic pr;
    pr = b && !m_prev;
    m_prev = b;
    if (m_pending) begin
      m_pending = 1'b0;
      if (m_code == PW) begin
        m_open = UC; m_fails = 0;
      end else begin
        m_fails++;
        if (m_fails == MAXA) m_alarm = LC;
      end
    end else if (m_open > 0) begin
      if (pr) m_open = 0; else m_open--;
    end else if (m_alarm > 0) begin
      m_alarm--;
      if (m_alarm == 0) m_fails = 0;
    end else if (pr) begin
      m_pending = 1'b1; m_code = p;
    end
  endtask

  function automatic logic [14:0] exp_vec();
    logic [3:0] att;
    logic [7:0] d;
    att = 4'(MAXA - m_fails);
    if (m_alarm > 0)     d = 8'hFF;
    else if (m_open > 0) d = {4'h0, m_code};
    else                 d = {4'hE, m_code};
    return {m_open > 0, m_alarm > 0, m_pending || m_open > 0 || m_alarm > 0, att, d};
  endfunction

  task automatic step(input logic b, input logic [3:0] p);
    check_btn = b;
    password_input = p;
    @(posedge clk);
    model_step(b, p);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== {3'b000, 4'd3, 8'hE0}) $display("FAIL reset: got %h want %h", obs, {3'b000, 4'd3, 8'hE0});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_correct();
    int on_cnt = 0, first_on = -1;
    for (int i = 0; i < 16; i++) begin
      step(i == 0, 4'hA);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL correct[%0d]: got %h want %h", i, obs, exp_vec());
      else n_pass++;
      if (unlock) begin on_cnt++; if (first_on < 0) first_on = i; end
      if (i == 1) begin
        n_checks++;
        if (display_out !== 8'h0A) $display("FAIL correct_disp_open: got %h want 0a", display_out);
        else n_pass++;
      end
    end
    n_checks++;
    if (on_cnt != UC || first_on != 1)
      $display("FAIL correct_window: got %0d cycles from %0d want %0d from 1", on_cnt, first_on, UC);
    else n_pass++;
    n_checks++;
    if ({attempts_left, display_out} !== 12'h3EA) $display("FAIL correct_relock: got %h want 3ea", {attempts_left, display_out});
    else n_pass++;
  endtask

  task automatic test_wrong_then_right();
    for (int i = 0; i < 16; i++) begin
      step(i == 0 || i == 4, (i < 4) ? 4'h3 : 4'hA);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL wrong_right[%0d]: got %h want %h", i, obs, exp_vec());
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if ({unlock, attempts_left, display_out} !== {1'b0, 4'd2, 8'hE3})
          $display("FAIL wrong_first: got %h want 2e3", {unlock, attempts_left, display_out});
        else n_pass++;
      end
      if (i == 5) begin
        n_checks++;
        if ({unlock, attempts_left} !== 5'h13) $display("FAIL right_second: got %h want 13", {unlock, attempts_left});
        else n_pass++;
      end
    end
  endtask

  task automatic test_lockout();
    int lo_cnt = 0, ul_cnt = 0;
    for (int i = 0; i < 31; i++) begin
      step(i == 0 || i == 4 || i == 8 || i == 12, (i == 12) ? 4'hA : 4'h5);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL lockout[%0d]: got %h want %h", i, obs, exp_vec());
      else n_pass++;
      if (lockout) lo_cnt++;
      if (unlock)  ul_cnt++;
      if (i == 10) begin
        n_checks++;
        if ({lockout, attempts_left, display_out} !== {1'b1, 4'd0, 8'hFF})
          $display("FAIL lockout_state: got %h want 10ff", {lockout, attempts_left, display_out});
        else n_pass++;
      end
    end
    n_checks++;
    if (lo_cnt != LC || ul_cnt != 0) $display("FAIL lockout_window: got %0d/%0d want %0d/0", lo_cnt, ul_cnt, LC);
    else n_pass++;
    n_checks++;
    if ({busy, attempts_left} !== 5'h03) $display("FAIL lockout_exit: got %h want 03", {busy, attempts_left});
    else n_pass++;
  endtask

  task automatic test_held();
    for (int i = 0; i < 24; i++) begin
      step(i < 20, 4'h5);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL held[%0d]: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (attempts_left !== 4'd2) $display("FAIL held_once: got %0d want 2", attempts_left);
    else n_pass++;
  endtask

  task automatic test_early_relock();
    for (int i = 0; i < 8; i++) begin
      step(i == 0 || i == 4, 4'hA);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL relock[%0d]: got %h want %h", i, obs, exp_vec());
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (unlock !== 1'b1) $display("FAIL relock_open: got %b want 1", unlock);
        else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if ({unlock, busy, attempts_left} !== 6'h03) $display("FAIL relock_drop: got %h want 03", {unlock, busy, attempts_left});
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 12; i++) begin
      step(i == 0 || i == 4 || i == 8, 4'h5);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL areset_pre[%0d]: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({lockout, attempts_left, display_out} !== {1'b0, 4'd3, 8'hE0})
      $display("FAIL areset_now: got %h want 03e0", {lockout, attempts_left, display_out});
    else n_pass++;
    check_btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 4'hA);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL areset_post[%0d]: got %h want %h", i, obs, exp_vec());
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (unlock !== 1'b1) $display("FAIL areset_unlock: got %b want 1", unlock);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic       b;
    logic [3:0] p;
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 2) == 0) ? 4'hA : 4'($urandom_range(0, 15));
      step(b, p);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong_then_right();
    test_lockout();
    test_held();
    test_early_relock();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
